cpu_datapath: RTL and testbench

//   Register-transfer datapath driven by the controller's strobes.
//   - Holds the program counter (PC), instruction register (IR) and accumulator (ACC), plus the ALU and the address mux.
//   - Returns opcode and zero to the controller, closing the fetch/decode/execute loop.
//   - Sits between the controller and the unified instruction/data memory.

---
 rtl/cpu_datapath_pkg.sv | 20 ++
 rtl/cpu_alu.sv | 26 ++
 rtl/cpu_datapath.sv | 71 +++++++
 tb/tb_cpu_datapath.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_datapath_pkg.sv
// Shared opcode encoding and widths for the accumulator CPU.
// Controller, datapath and benches all take opcodes from here.
package cpu_datapath_pkg;

  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: a is the accumulator, b is memory read data.
// Non-arithmetic opcodes pass the accumulator through unchanged.
module cpu_alu
  import cpu_datapath_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int OPW    = 3
) (
  input  logic [OPW-1:0]    opcode,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] out
);

  always_comb begin
    out = a;
    case (opcode)
      OP_ADD:  out = a + b;
      OP_AND:  out = a & b;
      OP_XOR:  out = a ^ b;
      OP_LDA:  out = b;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// PC, IR and accumulator with address mux, steered by controller strobes.
// Returns opcode and zero so the controller can sequence the next step.
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int OPW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              ld_ir,
  input  logic              inc_pc,
  input  logic              ld_pc,
  input  logic              ld_ac,
  input  logic              data_e,
  input  logic              halt,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_wdata_en,
  output logic [OPW-1:0]    opcode,
  output logic              zero,
  output logic [AWIDTH-1:0] pc_dbg
);

  if (OPW + AWIDTH != DWIDTH) begin : g_width_chk
    $error("cpu_datapath: OPW + AWIDTH must equal DWIDTH");
  end

  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] alu_out;
  logic [AWIDTH-1:0] ir_addr;

  assign ir_addr = ir[AWIDTH-1:0];
  assign opcode  = ir[DWIDTH-1:AWIDTH];

  cpu_alu #(
    .DWIDTH (DWIDTH),
    .OPW    (OPW)
  ) u_alu (
    .opcode (opcode),
    .a      (acc),
    .b      (mem_rdata),
    .out    (alu_out)
  );

  // ALU op and jump target both read the pre-edge IR
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
    end else if (!halt) begin
      if (ld_ir)       ir  <= mem_rdata;
      if (ld_pc)       pc  <= ir_addr;
      else if (inc_pc) pc  <= pc + AWIDTH'(1);
      if (ld_ac)       acc <= alu_out;
    end
  end

  assign mem_addr     = sel ? pc : ir_addr;
  assign mem_wdata    = acc;
  assign mem_wdata_en = data_e;
  assign zero         = (acc == '0);
  assign pc_dbg       = pc;

endmodule

// File: tb/tb_cpu_datapath.sv
// Vector table plus scoreboard queue for cpu_datapath.
// Expected state is pushed on drive and popped after the edge.
module tb_cpu_datapath;
  import cpu_datapath_pkg::*;

  logic       clk = 1'b0;
  logic       rst, sel, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr, pc_dbg;
  logic [7:0] mem_wdata;
  logic       mem_wdata_en, zero;
  logic [2:0] opcode;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .ld_ir        (ld_ir),
    .inc_pc       (inc_pc),
    .ld_pc        (ld_pc),
    .ld_ac        (ld_ac),
    .data_e       (data_e),
    .halt         (halt),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wdata_en (mem_wdata_en),
    .opcode       (opcode),
    .zero         (zero),
    .pc_dbg       (pc_dbg)
  );

  // ctl = {rst, sel, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}
  typedef struct {
    string      name;
    logic [7:0] ctl;
    logic [7:0] rd;
    logic [4:0] pc;
    logic [2:0] op;
    logic [7:0] acc;
    logic       z;
    logic [4:0] addr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t v(string n, logic [7:0] c, logic [7:0] rd,
                             logic [4:0] pc, logic [2:0] op,
                             logic [7:0] acc, logic z, logic [4:0] a);
    vec_t r;
    r.name = n; r.ctl = c; r.rd = rd; r.pc = pc;
    r.op = op; r.acc = acc; r.z = z; r.addr = a;
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    @(negedge clk);
    {rst, sel, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt} = r.ctl;
    mem_rdata = r.rd;
    sb.push_back(r);
  endtask

  task automatic check_next();
    vec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: queue empty");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".pc"},   32'(pc_dbg),       32'(e.pc));
    chk({e.name, ".op"},   32'(opcode),       32'(e.op));
    chk({e.name, ".acc"},  32'(mem_wdata),    32'(e.acc));
    chk({e.name, ".zero"}, 32'(zero),         32'(e.z));
    chk({e.name, ".addr"}, 32'(mem_addr),     32'(e.addr));
    chk({e.name, ".wen"},  32'(mem_wdata_en), 32'(e.ctl[1]));
  endtask

  initial begin
    {rst, sel, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt} = '0;
    mem_rdata = '0;

    vecs.push_back(v("rst0",       8'b0111_1111, 8'hFF, 5'h00, OP_HLT, 8'h00, 1, 5'h00));
    vecs.push_back(v("rst1",       8'b0111_1111, 8'hFF, 5'h00, OP_HLT, 8'h00, 1, 5'h00));
    vecs.push_back(v("fetch_ir",   8'b1110_0000, 8'h4A, 5'h00, OP_ADD, 8'h00, 1, 5'h00));
    vecs.push_back(v("fetch_inc",  8'b1101_0000, 8'h00, 5'h01, OP_ADD, 8'h00, 1, 5'h01));
    vecs.push_back(v("addr_ir",    8'b1000_0000, 8'h00, 5'h01, OP_ADD, 8'h00, 1, 5'h0A));
    vecs.push_back(v("acc_f0",     8'b1000_0100, 8'hF0, 5'h01, OP_ADD, 8'hF0, 0, 5'h0A));
    vecs.push_back(v("add_wrap",   8'b1000_0100, 8'h20, 5'h01, OP_ADD, 8'h10, 0, 5'h0A));
    vecs.push_back(v("ir_xor",     8'b1010_0000, 8'h80, 5'h01, OP_XOR, 8'h10, 0, 5'h00));
    vecs.push_back(v("xor_zero",   8'b1000_0100, 8'h10, 5'h01, OP_XOR, 8'h00, 1, 5'h00));
    vecs.push_back(v("ir_lda",     8'b1010_0000, 8'hA5, 5'h01, OP_LDA, 8'h00, 1, 5'h05));
    vecs.push_back(v("lda",        8'b1000_0100, 8'h5C, 5'h01, OP_LDA, 8'h5C, 0, 5'h05));
    vecs.push_back(v("ir_ac_same", 8'b1010_0100, 8'h40, 5'h01, OP_ADD, 8'h40, 0, 5'h00));
    vecs.push_back(v("add_new",    8'b1000_0100, 8'h01, 5'h01, OP_ADD, 8'h41, 0, 5'h00));
    vecs.push_back(v("ir_and",     8'b1010_0000, 8'h60, 5'h01, OP_AND, 8'h41, 0, 5'h00));
    vecs.push_back(v("and",        8'b1000_0100, 8'h0F, 5'h01, OP_AND, 8'h01, 0, 5'h00));
    vecs.push_back(v("ir_jmp",     8'b1010_0000, 8'hF3, 5'h01, OP_JMP, 8'h01, 0, 5'h13));
    vecs.push_back(v("jmp",        8'b1101_1000, 8'h00, 5'h13, OP_JMP, 8'h01, 0, 5'h13));
    vecs.push_back(v("ir_pc_same", 8'b1110_1000, 8'hE2, 5'h13, OP_JMP, 8'h01, 0, 5'h13));
    vecs.push_back(v("jmp_new",    8'b1000_1000, 8'h00, 5'h02, OP_JMP, 8'h01, 0, 5'h02));
    vecs.push_back(v("ir_jmp31",   8'b1010_0000, 8'hFF, 5'h02, OP_JMP, 8'h01, 0, 5'h1F));
    vecs.push_back(v("jmp31",      8'b1100_1000, 8'h00, 5'h1F, OP_JMP, 8'h01, 0, 5'h1F));
    vecs.push_back(v("pc_wrap",    8'b1101_0000, 8'h00, 5'h00, OP_JMP, 8'h01, 0, 5'h00));
    vecs.push_back(v("ir_lda0",    8'b1010_0000, 8'hA0, 5'h00, OP_LDA, 8'h01, 0, 5'h00));
    vecs.push_back(v("store",      8'b1000_0110, 8'h77, 5'h00, OP_LDA, 8'h77, 0, 5'h00));
    vecs.push_back(v("halt",       8'b1011_1111, 8'h00, 5'h00, OP_LDA, 8'h77, 0, 5'h00));
    vecs.push_back(v("halt_hold",  8'b1011_1111, 8'h00, 5'h00, OP_LDA, 8'h77, 0, 5'h00));
    vecs.push_back(v("ir_lda7",    8'b1010_0000, 8'hA7, 5'h00, OP_LDA, 8'h77, 0, 5'h07));
    vecs.push_back(v("set7_33",    8'b1000_1100, 8'h33, 5'h07, OP_LDA, 8'h33, 0, 5'h07));
    vecs.push_back(v("rst_mid",    8'b0000_0100, 8'h55, 5'h00, OP_HLT, 8'h00, 1, 5'h00));
    vecs.push_back(v("post_rst",   8'b1000_0000, 8'h55, 5'h00, OP_HLT, 8'h00, 1, 5'h00));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check_next();
    end

    // long inc_pc run from reset: PC counts and wraps past 31
    drive(v("seq_rst", 8'b0000_0000, 8'h00, 5'h00, OP_HLT, 8'h00, 1, 5'h00));
    check_next();
    for (int n = 1; n <= 40; n++) begin
      drive(v("seq_inc", 8'b1101_0000, 8'h00, 5'(n % 32), OP_HLT,
              8'h00, 1, 5'(n % 32)));
      check_next();
    end

    // halt frozen across several cycles, then release resumes counting
    for (int n = 0; n < 3; n++) begin
      drive(v("seq_halt", 8'b1111_1101, 8'hC4, 5'h08, OP_HLT, 8'h00, 1, 5'h08));
      check_next();
    end
    drive(v("seq_resume", 8'b1101_0000, 8'h00, 5'h09, OP_HLT, 8'h00, 1, 5'h09));
    check_next();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
